// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : PC register and instruction-fetch sequencer presenting one
//               instruction at a time to a single-cycle datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  CNT_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [PC_WIDTH-1:0]  BRANCH_TARGET,
  input  logic                 TAKE_BRANCH,
  input  logic                 STALL,
  input  logic                 IMEM_BUSYWAIT,
  input  logic [31:0]          INSTR_IN,
  output logic                 IMEM_READ,
  output logic [PC_WIDTH-1:0]  PC,
  output logic [PC_WIDTH-1:0]  PC_PLUS4,
  output logic [31:0]          INSTR_OUT,
  output logic                 INSTR_VALID,
  output logic                 ALIGN_ERR,
  output logic [CNT_WIDTH-1:0] RETIRED
);

  localparam logic [PC_WIDTH-1:0]  PC_FOUR = PC_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   fetch_done;
  logic   commit;

  assign PC_PLUS4 = PC + PC_FOUR;

  always_comb begin
    state_next = state;
    IMEM_READ  = 1'b0;
    fetch_done = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        IMEM_READ = 1'b1;
        if (!IMEM_BUSYWAIT) begin
          fetch_done = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        if (!STALL) begin
          commit     = 1'b1;
          state_next = FETCH;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      PC          <= RESET_PC;
      INSTR_OUT   <= '0;
      INSTR_VALID <= 1'b0;
      ALIGN_ERR   <= 1'b0;
      RETIRED     <= '0;
    end else begin
      state <= state_next;
      if (fetch_done) begin
        INSTR_OUT   <= INSTR_IN;
        INSTR_VALID <= 1'b1;
      end
      // Branch/target are only meaningful at the committing edge.
      if (commit) begin
        PC          <= TAKE_BRANCH ? {BRANCH_TARGET[PC_WIDTH-1:2], 2'b00} : PC_PLUS4;
        RETIRED     <= RETIRED + CNT_ONE;
        INSTR_VALID <= 1'b0;
        if (TAKE_BRANCH && (BRANCH_TARGET[1:0] != 2'b00)) begin
          ALIGN_ERR <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// Testbench for pc_fetch_unit: directed scenarios plus randomized instruction
// streams checked against an instruction-level reference model.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] BRANCH_TARGET = '0;
  logic        TAKE_BRANCH = 1'b0;
  logic        STALL = 1'b0;
  logic        IMEM_BUSYWAIT = 1'b0;
  logic [31:0] INSTR_IN = '0;
  logic        IMEM_READ;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;
  logic [31:0] INSTR_OUT;
  logic        INSTR_VALID;
  logic        ALIGN_ERR;
  logic [31:0] RETIRED;

  pc_fetch_unit #(
    .PC_WIDTH (32),
    .RESET_PC (32'h0000_0000),
    .CNT_WIDTH(32)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .BRANCH_TARGET(BRANCH_TARGET),
    .TAKE_BRANCH  (TAKE_BRANCH),
    .STALL        (STALL),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
    .INSTR_IN     (INSTR_IN),
    .IMEM_READ    (IMEM_READ),
    .PC           (PC),
    .PC_PLUS4     (PC_PLUS4),
    .INSTR_OUT    (INSTR_OUT),
    .INSTR_VALID  (INSTR_VALID),
    .ALIGN_ERR    (ALIGN_ERR),
    .RETIRED      (RETIRED)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Instruction-level reference model state
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic        m_align;
  logic [31:0] m_instr;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reset and release; leaves the DUT in its first fetch cycle.
  task automatic do_reset();
    RESET = 1'b1;
    STALL = 1'b0;
    TAKE_BRANCH = 1'b0;
    IMEM_BUSYWAIT = 1'b0;
    step();
    RESET = 1'b0;
    step();
    m_pc = 32'h0;
    m_ret = 32'h0;
    m_align = 1'b0;
    m_instr = 32'h0;
  endtask

  // Runs one instruction from its FETCH cycle through commit.
  task automatic run_instr(input logic [31:0] instr, input int waits, input int stalls,
                           input logic br, input logic [31:0] tgt);
    for (int i = 0; i <= waits; i++) begin
      tests++;
      if (IMEM_READ !== 1'b1 || INSTR_VALID !== 1'b0 || PC !== m_pc || PC_PLUS4 !== m_pc + 32'd4) begin
        fails++;
        $display("FAIL fetch_phase: read=%b valid=%b pc=%h pc4=%h, want read=1 valid=0 pc=%h pc4=%h",
                 IMEM_READ, INSTR_VALID, PC, PC_PLUS4, m_pc, m_pc + 32'd4);
      end
      TAKE_BRANCH = 1'($urandom);
      STALL = 1'($urandom);
      BRANCH_TARGET = $urandom;
      IMEM_BUSYWAIT = (i < waits);
      INSTR_IN = (i < waits) ? $urandom : instr;
      step();
    end
    m_instr = instr;
    for (int i = 0; i <= stalls; i++) begin
      tests++;
      if (IMEM_READ !== 1'b0 || INSTR_VALID !== 1'b1 || INSTR_OUT !== m_instr || PC !== m_pc || RETIRED !== m_ret) begin
        fails++;
        $display("FAIL exec_phase: read=%b valid=%b instr=%h pc=%h ret=%0d, want read=0 valid=1 instr=%h pc=%h ret=%0d",
                 IMEM_READ, INSTR_VALID, INSTR_OUT, PC, RETIRED, m_instr, m_pc, m_ret);
      end
      IMEM_BUSYWAIT = 1'($urandom);
      INSTR_IN = $urandom;
      STALL = (i < stalls);
      TAKE_BRANCH = (i < stalls) ? 1'($urandom) : br;
      BRANCH_TARGET = (i < stalls) ? $urandom : tgt;
      step();
    end
    STALL = 1'b0;
    TAKE_BRANCH = 1'b0;
    IMEM_BUSYWAIT = 1'b0;
    m_pc = br ? (tgt & ~32'd3) : m_pc + 32'd4;
    m_align = m_align | (br && tgt[1:0] != 2'b00);
    m_ret = m_ret + 32'd1;
    tests++;
    if (PC !== m_pc || RETIRED !== m_ret || ALIGN_ERR !== m_align || INSTR_VALID !== 1'b0 || IMEM_READ !== 1'b1) begin
      fails++;
      $display("FAIL commit: pc=%h ret=%0d align=%b valid=%b read=%b, want pc=%h ret=%0d align=%b valid=0 read=1",
               PC, RETIRED, ALIGN_ERR, INSTR_VALID, IMEM_READ, m_pc, m_ret, m_align);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    IMEM_BUSYWAIT = 1'b0;
    INSTR_IN = 32'hFFFF_FFFF;
    step();
    tests++;
    if (PC !== 32'h0 || INSTR_OUT !== 32'h0 || INSTR_VALID !== 1'b0 || IMEM_READ !== 1'b0 ||
        ALIGN_ERR !== 1'b0 || RETIRED !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: pc=%h instr=%h valid=%b read=%b align=%b ret=%0d, want all zero",
               PC, INSTR_OUT, INSTR_VALID, IMEM_READ, ALIGN_ERR, RETIRED);
    end
    RESET = 1'b0;
    step();
    tests++;
    if (IMEM_READ !== 1'b1 || PC !== 32'h0) begin
      fails++;
      $display("FAIL idle_to_fetch: read=%b pc=%h, want read=1 pc=0", IMEM_READ, PC);
    end
    m_pc = 32'h0;
    m_ret = 32'h0;
    m_align = 1'b0;
    m_instr = 32'h0;
  endtask

  task automatic test_sequential();
    do_reset();
    for (int k = 0; k < 3; k++) run_instr($urandom, 0, 0, 1'b0, 32'h0);
    tests++;
    if (PC !== 32'hC || RETIRED !== 32'd3) begin
      fails++;
      $display("FAIL sequential: pc=%h ret=%0d, want pc=c ret=3", PC, RETIRED);
    end
  endtask

  task automatic test_busywait();
    do_reset();
    run_instr(32'h1111_0001, 0, 0, 1'b0, 32'h0);
    run_instr(32'h1111_0002, 0, 0, 1'b0, 32'h0);
    run_instr(32'hCAFE_0008, 5, 0, 1'b0, 32'h0);
  endtask

  task automatic test_stall_branch();
    do_reset();
    run_instr(32'h2222_0000, 0, 0, 1'b0, 32'h0);
    run_instr(32'h2222_0004, 0, 3, 1'b1, 32'h40);
    tests++;
    if (PC !== 32'h40 || RETIRED !== 32'd2) begin
      fails++;
      $display("FAIL stall_branch: pc=%h ret=%0d, want pc=40 ret=2", PC, RETIRED);
    end
  endtask

  task automatic test_align();
    do_reset();
    run_instr(32'h3333_0000, 0, 0, 1'b1, 32'h22);
    tests++;
    if (PC !== 32'h20 || ALIGN_ERR !== 1'b1) begin
      fails++;
      $display("FAIL align_branch: pc=%h align=%b, want pc=20 align=1", PC, ALIGN_ERR);
    end
    for (int k = 0; k < 3; k++) run_instr($urandom, $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, 32'h0);
    tests++;
    if (ALIGN_ERR !== 1'b1) begin
      fails++;
      $display("FAIL align_sticky: align=%b, want 1", ALIGN_ERR);
    end
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    run_instr(32'h4444_0000, 0, 0, 1'b1, 32'h100);
    IMEM_BUSYWAIT = 1'b1;
    step();
    step();
    RESET = 1'b1;
    IMEM_BUSYWAIT = 1'b0;
    INSTR_IN = 32'hDEAD_BEEF;
    step();
    tests++;
    if (PC !== 32'h0 || IMEM_READ !== 1'b0 || INSTR_VALID !== 1'b0 || INSTR_OUT !== 32'h0 || RETIRED !== 32'h0) begin
      fails++;
      $display("FAIL reset_midfetch: pc=%h read=%b valid=%b instr=%h ret=%0d, want all zero",
               PC, IMEM_READ, INSTR_VALID, INSTR_OUT, RETIRED);
    end
    RESET = 1'b0;
    step();
    tests++;
    if (INSTR_OUT !== 32'h0 || IMEM_READ !== 1'b1 || PC !== 32'h0) begin
      fails++;
      $display("FAIL reset_no_latch: instr=%h read=%b pc=%h, want instr=0 read=1 pc=0", INSTR_OUT, IMEM_READ, PC);
    end
    m_pc = 32'h0;
    m_ret = 32'h0;
    m_align = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    run_instr(32'h5555_0000, 0, 0, 1'b1, 32'hFFFF_FFFC);
    tests++;
    if (PC_PLUS4 !== 32'h0) begin
      fails++;
      $display("FAIL wrap_plus4: pc4=%h, want 0", PC_PLUS4);
    end
    run_instr(32'h5555_0001, 0, 0, 1'b0, 32'h0);
    tests++;
    if (PC !== 32'h0 || PC_PLUS4 !== 32'h4 || ALIGN_ERR !== 1'b0) begin
      fails++;
      $display("FAIL wrap: pc=%h pc4=%h align=%b, want pc=0 pc4=4 align=0", PC, PC_PLUS4, ALIGN_ERR);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 60; k++) begin
      run_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_busywait();
    test_stall_branch();
    test_align();
    test_reset_midfetch();
    test_wrap();
    test_random();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
